// File: rtl/fir_decim_pkg.sv
// fir_decim_pkg: quantization constants, dequantize helper, default taps and FSM states
package fir_decim_pkg;
  localparam int BITS = 10;
  localparam int DATA_WIDTH = 32;
  localparam logic signed [DATA_WIDTH-1:0] DQ_BIAS = (1 << BITS) - 1;
  typedef enum logic [1:0] {S_LOAD, S_MAC, S_WRITE} state_e;
  localparam logic signed [DATA_WIDTH-1:0] DEFAULT_COEFFS [32] = '{
    -3, -5, -6, -4, 0, 8, 19, 33, 48, 63, 77, 88, 96, 101, 104, 105,
    105, 104, 101, 96, 88, 77, 63, 48, 33, 19, 8, 0, -4, -6, -5, -3
  };
  function automatic logic signed [DATA_WIDTH-1:0] DEQUANTIZE(input logic signed [DATA_WIDTH-1:0] p);
    return p[DATA_WIDTH-1] ? (p + DQ_BIAS) >>> BITS : p >>> BITS;
  endfunction
endpackage

// File: rtl/fir_decim.sv
// fir_decim: streaming FIR low-pass with integer decimation between two FIFOs
module fir_decim import fir_decim_pkg::*; #(
  parameter int DATA_WIDTH = fir_decim_pkg::DATA_WIDTH,
  parameter int TAPS = 32,
  parameter int DECIM = 8,
  parameter logic signed [DATA_WIDTH-1:0] COEFFS [TAPS] = DEFAULT_COEFFS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] out_din,
  input  logic                  out_full,
  output logic                  out_wr_en
);
  localparam int CW = $clog2(DECIM + 1);
  localparam int TW = $clog2(TAPS);
  state_e state_q, state_d;
  logic signed [DATA_WIDTH-1:0] sr_q [TAPS];
  logic [CW-1:0] load_cnt_q, load_cnt_d;
  logic [TW-1:0] tap_cnt_q, tap_cnt_d;
  logic signed [DATA_WIDTH-1:0] acc_q, acc_d, out_din_q, out_din_d;
  logic signed [DATA_WIDTH-1:0] prod, sum;
  assign in_rd_en = !reset && state_q == S_LOAD && !in_empty;
  assign out_wr_en = !reset && state_q == S_WRITE && !out_full;
  assign out_din = out_din_q;
  assign prod = sr_q[tap_cnt_q] * COEFFS[tap_cnt_q];
  assign sum = acc_q + DEQUANTIZE(prod);
  // sample history: shift in one sample per pop, cleared on reset
  always_ff @(posedge clock) begin
    if (reset) sr_q <= '{default: '0};
    else if (in_rd_en) begin
      for (int k = TAPS - 1; k > 0; k--) sr_q[k] <= sr_q[k-1];
      sr_q[0] <= in_dout;
    end
  end
  // control and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_LOAD;
      load_cnt_q <= '0;
      tap_cnt_q <= '0;
      acc_q <= '0;
      out_din_q <= '0;
    end else begin
      state_q <= state_d;
      load_cnt_q <= load_cnt_d;
      tap_cnt_q <= tap_cnt_d;
      acc_q <= acc_d;
      out_din_q <= out_din_d;
    end
  end
  // load DECIM samples, accumulate one tap per cycle, then hold the result until written
  always_comb begin
    state_d = state_q;
    load_cnt_d = load_cnt_q;
    tap_cnt_d = tap_cnt_q;
    acc_d = acc_q;
    out_din_d = out_din_q;
    unique case (state_q)
      S_LOAD: if (in_rd_en) begin
        load_cnt_d = load_cnt_q + 1'b1;
        if (load_cnt_q == CW'(DECIM - 1)) begin
          state_d = S_MAC;
          load_cnt_d = '0;
          tap_cnt_d = '0;
          acc_d = '0;
        end
      end
      S_MAC: begin
        acc_d = sum;
        tap_cnt_d = tap_cnt_q + 1'b1;
        if (tap_cnt_q == TW'(TAPS - 1)) begin
          state_d = S_WRITE;
          out_din_d = sum;
        end
      end
      S_WRITE: if (out_wr_en) begin
        state_d = S_LOAD;
        load_cnt_d = '0;
      end
      default: state_d = S_LOAD;
    endcase
  end
endmodule

// File: tb/tb_fir_decim.sv
// tb_fir_decim: directed scenarios for fir_decim across three coefficient sets
module tb_fir_decim;
  localparam logic signed [31:0] C_IMP [32] = '{
    1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16,
    17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31, 32
  };
  localparam logic signed [31:0] C_DC [32] = '{default: 32'sd10};
  localparam logic signed [31:0] C_NEG [2] = '{32'sd1, 32'sd0};
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic empty [3];
  logic full [3];
  logic rd [3];
  logic wr [3];
  logic [31:0] din [3];
  logic [31:0] dout [3];
  logic signed [31:0] src [$];
  logic signed [31:0] got [$];
  int wr_cyc [$];
  int lat [$];
  int sel = 0;
  int cyc = 0;
  int last_pop = 0;
  int pops = 0;
  int checks = 0;
  int failures = 0;
  bit gap_en = 1'b0;
  bit gap = 1'b0;
  bit full_req = 1'b0;
  bit last_rd, last_wr;

  always #5 clock = ~clock;

  fir_decim #(.TAPS(32), .DECIM(8), .COEFFS(C_IMP)) u_imp (
    .clock(clock), .reset(reset), .in_dout(din[0]), .in_empty(empty[0]), .in_rd_en(rd[0]),
    .out_din(dout[0]), .out_full(full[0]), .out_wr_en(wr[0]));
  fir_decim #(.TAPS(32), .DECIM(8), .COEFFS(C_DC)) u_dc (
    .clock(clock), .reset(reset), .in_dout(din[1]), .in_empty(empty[1]), .in_rd_en(rd[1]),
    .out_din(dout[1]), .out_full(full[1]), .out_wr_en(wr[1]));
  fir_decim #(.TAPS(2), .DECIM(1), .COEFFS(C_NEG)) u_neg (
    .clock(clock), .reset(reset), .in_dout(din[2]), .in_empty(empty[2]), .in_rd_en(rd[2]),
    .out_din(dout[2]), .out_full(full[2]), .out_wr_en(wr[2]));

  task automatic tick();
    gap = gap_en ? !gap : 1'b0;
    for (int i = 0; i < 3; i++) begin
      empty[i] = (i != sel) || gap || (src.size() == 0);
      din[i] = (src.size() != 0) ? src[0] : '0;
      full[i] = (i == sel) && full_req;
    end
    #1;
    last_rd = rd[sel];
    last_wr = wr[sel];
    if (last_rd) begin
      void'(src.pop_front());
      pops++;
      last_pop = cyc;
    end
    if (last_wr) begin
      got.push_back(dout[sel]);
      wr_cyc.push_back(cyc);
      lat.push_back(cyc - last_pop);
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic clear_logs();
    got.delete();
    wr_cyc.delete();
    lat.delete();
    pops = 0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bit saw_rd = 1'b0;
    sel = 0;
    src.push_back(32'sd1024);
    repeat (3) begin
      tick();
      saw_rd |= last_rd;
    end
    checks++;
    if (saw_rd !== 1'b0) begin failures++; $display("FAIL reset_rd: in_rd_en=%0b required 0", saw_rd); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr[i] !== 1'b0 || dout[i] !== 32'd0) begin
        failures++;
        $display("FAIL reset_out[%0d]: wr=%0b din=%0d required wr=0 din=0", i, wr[i], $signed(dout[i]));
      end
    end
    src.delete();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_impulse();
    int exp_v [5] = '{8, 16, 24, 32, 0};
    sel = 0;
    clear_logs();
    src.push_back(32'sd1024);
    repeat (39) src.push_back(32'sd0);
    for (int n = 0; n < 400 && got.size() < 5; n++) tick();
    checks++;
    if (got.size() != 5) begin failures++; $display("FAIL impulse_count: got %0d outputs required 5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_v[i]) begin failures++; $display("FAIL impulse[%0d]: got %0d required %0d", i, got[i], exp_v[i]); end
    end
    if (got.size() >= 2) begin
      checks++;
      if (lat[0] != 33) begin failures++; $display("FAIL latency: got %0d required 33", lat[0]); end
      checks++;
      if (wr_cyc[1] - wr_cyc[0] != 41) begin failures++; $display("FAIL period: got %0d required 41", wr_cyc[1] - wr_cyc[0]); end
    end
  endtask

  task automatic test_dc();
    int exp_v [6] = '{80, 160, 240, 320, 320, 320};
    sel = 1;
    clear_logs();
    repeat (48) src.push_back(32'sd1024);
    for (int n = 0; n < 400 && got.size() < 6; n++) tick();
    checks++;
    if (got.size() != 6) begin failures++; $display("FAIL dc_count: got %0d outputs required 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_v[i]) begin failures++; $display("FAIL dc[%0d]: got %0d required %0d", i, got[i], exp_v[i]); end
    end
  endtask

  task automatic test_neg_rounding();
    int exp_v [4] = '{0, -2, 4, -1};
    sel = 2;
    clear_logs();
    src.push_back(-32'sd1);
    src.push_back(-32'sd2048);
    src.push_back(32'sd5000);
    src.push_back(-32'sd1025);
    for (int n = 0; n < 40 && got.size() < 4; n++) tick();
    checks++;
    if (got.size() != 4) begin failures++; $display("FAIL neg_count: got %0d outputs required 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_v[i]) begin failures++; $display("FAIL neg[%0d]: got %0d required %0d", i, got[i], exp_v[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit bad = 1'b0;
    logic [31:0] held;
    sel = 1;
    clear_logs();
    full_req = 1'b1;
    repeat (16) src.push_back(32'sd1024);
    for (int n = 0; n < 50 && src.size() > 8; n++) tick();
    repeat (32) tick();
    held = dout[1];
    checks++;
    if ($signed(held) !== 32'sd320) begin failures++; $display("FAIL bp_value: got %0d required 320", $signed(held)); end
    repeat (20) begin
      tick();
      bad |= last_rd || last_wr || (dout[1] !== held);
    end
    checks++;
    if (bad) begin failures++; $display("FAIL bp_stall: activity while full, got flag %0b required 0", bad); end
    full_req = 1'b0;
    tick();
    checks++;
    if (last_wr !== 1'b1 || got.size() != 1) begin
      failures++;
      $display("FAIL bp_release: wr=%0b writes=%0d required wr=1 writes=1", last_wr, got.size());
    end
    repeat (20) tick();
    checks++;
    if (got.size() != 1) begin failures++; $display("FAIL bp_single: got %0d writes required 1", got.size()); end
    for (int n = 0; n < 100 && got.size() < 2; n++) tick();
    checks++;
    if (got.size() != 2 || got[got.size()-1] !== 32'sd320) begin
      failures++;
      $display("FAIL bp_next: writes=%0d last=%0d required writes=2 last=320", got.size(), got[got.size()-1]);
    end
  endtask

  task automatic test_starved();
    int exp_v [6] = '{80, 160, 240, 320, 320, 320};
    sel = 1;
    pulse_reset();
    clear_logs();
    gap_en = 1'b1;
    repeat (48) src.push_back(32'sd1024);
    for (int n = 0; n < 800 && got.size() < 6; n++) tick();
    gap_en = 1'b0;
    checks++;
    if (got.size() != 6) begin failures++; $display("FAIL starved_count: got %0d outputs required 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_v[i]) begin failures++; $display("FAIL starved[%0d]: got %0d required %0d", i, got[i], exp_v[i]); end
    end
    checks++;
    if (pops != 48 || src.size() != 0) begin
      failures++;
      $display("FAIL starved_pops: got %0d pops, %0d left required 48 pops, 0 left", pops, src.size());
    end
  endtask

  task automatic test_reset_mid_mac();
    sel = 0;
    pulse_reset();
    clear_logs();
    src.push_back(32'sd1024);
    repeat (7) src.push_back(32'sd0);
    for (int n = 0; n < 40 && src.size() > 0; n++) tick();
    repeat (5) tick();
    pulse_reset();
    repeat (50) tick();
    checks++;
    if (got.size() != 0) begin failures++; $display("FAIL mid_mac_write: got %0d writes required 0", got.size()); end
    test_impulse();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      empty[i] = 1'b1;
      full[i] = 1'b0;
      din[i] = '0;
    end
    @(negedge clock);
    test_reset();
    test_impulse();
    test_dc();
    test_neg_rounding();
    test_backpressure();
    test_starved();
    test_reset_mid_mac();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/fir_decim.md
# fir_decim

Streaming fixed-point FIR low-pass filter with integer decimation, used as the channel/audio filter stage in the FM receive chain. It pops quantized samples (Q.10, BITS=10) from an upstream FIFO and multiplies them by quantized coefficients. Each product is dequantized with round-toward-zero, the results are summed, and one filtered sample per DECIM inputs is pushed to a downstream FIFO. Its arithmetic is the hardware counterpart of the shared quantize/dequantize helpers.

## Interface
- DATA_WIDTH, 32, sample/coefficient/accumulator width (signed)
- TAPS, 32, number of filter taps (≥ DECIM, ≥ 2)
- DECIM, 8, decimation factor (≥ 1)
- COEFFS, package default array, TAPS signed DATA_WIDTH quantized coefficients, index k applied to the k-th newest sample
- clock  in  1  sole clock; everything on rising edge
- reset  in  1  synchronous, active-high
- in_dout  in  DATA_WIDTH  upstream FIFO read data (valid whenever in_empty=0)
- in_empty  in  1  upstream FIFO empty
- in_rd_en  out  1  pop upstream FIFO this cycle
- out_din  out  DATA_WIDTH  filtered sample to downstream FIFO
- out_full  in  1  downstream FIFO full
- out_wr_en  out  1  push out_din this cycle

## Operation
- Shift register sr[0..TAPS-1], sr[0] newest; a pop shifts sr[k]←sr[k-1] and sets sr[0]←in_dout.
- States:
  - S_LOAD: in_rd_en = !in_empty (combinational); each pop increments load_cnt. After the DECIM-th pop → S_MAC with tap_cnt=0, acc=0.
  - S_MAC: one tap per cycle, acc ← acc + DQ(sr[tap_cnt]*COEFFS[tap_cnt]). After tap TAPS-1 is accumulated → S_WRITE, result latched into out_din.
  - S_WRITE: out_wr_en = !out_full; on a write → S_LOAD, load_cnt=0.
- Product: signed DATA_WIDTH×DATA_WIDTH, truncated to DATA_WIDTH (wraps as 32-bit int).
- DQ(p): if p negative, (p + 2^BITS − 1) >>> BITS; otherwise p >>> BITS. Rounds toward zero.
- Accumulator: DATA_WIDTH signed, wraps on overflow, no saturation.
- No reads occur in S_MAC or S_WRITE. Upstream stalls in those states via FIFO backpressure.

## Timing
- Reset (sync): state=S_LOAD, sr all 0, load_cnt=0, tap_cnt=0, acc=0, out_din=0, out_wr_en=0. in_rd_en=0 while reset is high.
- Reset mid-MAC or mid-WRITE:
  - The pending output is discarded and never written.
  - The sample history is cleared.
- Pops in S_LOAD: at most one per cycle. Empty cycles insert bubbles with no count change.
- Latency, last input pop to out_wr_en (with out_full=0): TAPS+1 cycles. The pop occurs in cycle t, MAC runs t+1..t+TAPS, the write occurs in t+TAPS+1.
- Throughput ceiling: one output per DECIM+TAPS+1 cycles.
- Backpressure: out_din stays stable in S_WRITE until out_wr_en fires.
- First output uses zero history for unfilled taps. No priming or warm-up suppression.

## Structure
- Shared package (existing quantization package, extended):
  - BITS, DATA_WIDTH
  - DEQUANTIZE function, reused for DQ
  - default coefficient array constant
  - state enum typedef {S_LOAD, S_MAC, S_WRITE}
- Single module, no sub-modules. The multiply, DQ and add form one combinational path registered into acc.
- If timing fails at target clock, a product pipeline register adds exactly one cycle to latency. The spec then reads TAPS+2.

## Test plan
- Impulse: COEFFS[k]=k+1, TAPS=32, DECIM=8; input 1024 followed by zeros → outputs 8, 16, 24, 32, then 0.
- DC: all inputs 1024, COEFFS all 10 → outputs 80, 160, 240, then 320 from the 4th output onward.
- Negative rounding: TAPS=2, DECIM=1, COEFFS={1,0}; input −1 → output 0 (not −1). Input −2048 → output −2, since −2048·1 = −2048 and DQ gives −2.
- Backpressure: hold out_full=1 for 20 cycles in S_WRITE → out_wr_en=0 and in_rd_en=0 throughout, out_din constant; on release, exactly one write.
- Starved input: in_empty toggling every other cycle → outputs identical to the DC case, no duplicate or missing pops.
- Reset mid-MAC: assert reset 5 cycles into S_MAC → no write. Next impulse run matches the impulse case from the start.
